// File: rtl/legv8_ctrl_if.sv
// Control/status bus between the LEGv8 microsequencer and the datapath+memory.
// No handshake on this bus: ControlWord is valid every cycle, and IR/flags are sampled as plain level inputs.
interface legv8_ctrl_if;
  logic [31:0] IR;
  logic [3:0]  sr_flags;
  logic [3:0]  alu_flags;
  logic [39:0] ControlWord;

  modport master (input IR, sr_flags, alu_flags, output ControlWord);
  modport slave  (output IR, sr_flags, alu_flags, input ControlWord);
endinterface

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 microsequencer: fetch, decode, and sequence ALU/load/store/branch/halt
// by emitting a 40-bit ControlWord whose NS field feeds the state register.
module legv8_control_unit #(
  parameter logic [4:0] LINK_REG = 5'd30,
  parameter logic [4:0] ZERO_REG = 5'd31
) (
  input  logic         clock,
  input  logic         reset,
  legv8_ctrl_if.master bus,
  output logic [2:0]   state,
  output logic         halted,
  output logic         illegal
);

  localparam logic [2:0] S_FETCH0 = 3'b000;
  localparam logic [2:0] S_FETCH1 = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_LOAD1  = 3'b011;
  localparam logic [2:0] S_HALT   = 3'b111;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef struct packed {
    logic [2:0] cgs;
    logic [2:0] ns;
    logic       as_pc;
    logic [1:0] ds;
    logic [1:0] ps;
    logic       pc_sel;
    logic       b_sel;
    logic       il;
    logic       sl;
    logic [4:0] fs;
    logic       c0;
    logic [1:0] size;
    logic       mw;
    logic       rw;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
  } cw_t;

  cw_t        cw;
  logic [2:0] state_next;
  logic       illegal_next;
  logic       dec_illegal;
  logic       arith;
  logic       imm;

  logic [4:0] rd, rn, rm;
  assign rd = bus.IR[4:0];
  assign rn = bus.IR[9:5];
  assign rm = bus.IR[20:16];

  // Shift amount reaches the ALU through the CGS=000 constant path, and only Z of the live flags matters.
  logic unused_bits;
  assign unused_bits = ^{bus.IR[15:10], bus.alu_flags[3:1]};

  // Condition evaluation on registered flags {V,C,N,Z}; codes 1110/1111 are always true.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic v, cf, n, z, r;
    {v, cf, n, z} = f;
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cf;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cf & ~z;
      3'd5:    r = (n == v);
      3'd6:    r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && (c[3:1] != 3'd7)) r = ~r;
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      illegal <= illegal_next;
    end
  end

  always_comb begin
    state_next   = cw.ns;
    illegal_next = illegal;
    if (state == S_EXEC && dec_illegal) illegal_next = 1'b1;
    if (state[2] && state != S_HALT)    illegal_next = 1'b1;
  end

  always_comb begin
    cw          = '0;
    cw.da       = ZERO_REG;
    cw.sa       = ZERO_REG;
    cw.sb       = ZERO_REG;
    dec_illegal = 1'b0;
    arith       = 1'b0;
    imm         = 1'b0;
    case (state)
      S_FETCH0: begin
        cw.as_pc = 1'b1;
        cw.size  = 2'b10;
        cw.ns    = S_FETCH1;
      end
      S_FETCH1: begin
        cw.as_pc = 1'b1;
        cw.ds    = 2'b11;
        cw.il    = 1'b1;
        cw.ps    = 2'b01;
        cw.size  = 2'b10;
        cw.ns    = S_EXEC;
      end
      S_EXEC: begin
        cw.ns = S_FETCH0;
        casez (bus.IR[31:21])
          11'b10001011000: begin arith = 1'b1; cw.fs = FS_ADD; end
          11'b10101011000: begin arith = 1'b1; cw.fs = FS_ADD; cw.sl = 1'b1; end
          11'b11001011000: begin arith = 1'b1; cw.fs = FS_SUB; cw.c0 = 1'b1; end
          11'b11101011000: begin arith = 1'b1; cw.fs = FS_SUB; cw.c0 = 1'b1; cw.sl = 1'b1; end
          11'b10001010000: begin arith = 1'b1; cw.fs = FS_AND; end
          11'b10101010000: begin arith = 1'b1; cw.fs = FS_OR;  end
          11'b11001010000: begin arith = 1'b1; cw.fs = FS_XOR; end
          11'b1001000100?: begin arith = 1'b1; imm = 1'b1; cw.fs = FS_ADD; end
          11'b1101000100?: begin arith = 1'b1; imm = 1'b1; cw.fs = FS_SUB; cw.c0 = 1'b1; end
          11'b1001001000?: begin arith = 1'b1; imm = 1'b1; cw.fs = FS_AND; end
          11'b1011001000?: begin arith = 1'b1; imm = 1'b1; cw.fs = FS_OR;  end
          11'b11010011011: begin arith = 1'b1; imm = 1'b1; cw.fs = FS_LSL; end
          11'b11010011010: begin arith = 1'b1; imm = 1'b1; cw.fs = FS_LSR; end
          11'b110100101??: begin
            cw.b_sel = 1'b1;
            cw.cgs   = 3'b100;
            cw.fs    = FS_OR;
            cw.da    = rd;
            cw.rw    = 1'b1;
          end
          11'b11111000010: begin
            cw.sa    = rn;
            cw.b_sel = 1'b1;
            cw.cgs   = 3'b001;
            cw.fs    = FS_ADD;
            cw.size  = 2'b11;
            cw.ns    = S_LOAD1;
          end
          11'b11111000000: begin
            cw.sa    = rn;
            cw.sb    = rd;
            cw.b_sel = 1'b1;
            cw.cgs   = 3'b001;
            cw.fs    = FS_ADD;
            cw.ds    = 2'b01;
            cw.mw    = 1'b1;
            cw.size  = 2'b11;
          end
          11'b000101?????: begin cw.cgs = 3'b010; cw.ps = 2'b10; end
          // BL links the PC that FETCH1 already advanced.
          11'b100101?????: begin
            cw.cgs = 3'b010;
            cw.ps  = 2'b10;
            cw.ds  = 2'b10;
            cw.da  = LINK_REG;
            cw.rw  = 1'b1;
          end
          11'b11010110000: begin cw.sa = rn; cw.ps = 2'b11; cw.pc_sel = 1'b1; end
          11'b10110100???: begin
            cw.sa  = rd;
            cw.fs  = FS_OR;
            cw.cgs = 3'b011;
            cw.ps  = bus.alu_flags[0] ? 2'b10 : 2'b00;
          end
          11'b10110101???: begin
            cw.sa  = rd;
            cw.fs  = FS_OR;
            cw.cgs = 3'b011;
            cw.ps  = bus.alu_flags[0] ? 2'b00 : 2'b10;
          end
          11'b01010100???: begin
            cw.cgs = 3'b011;
            cw.ps  = cond_true(bus.IR[3:0], bus.sr_flags) ? 2'b10 : 2'b00;
          end
          11'b11010100010: cw.ns = S_HALT;
          default: begin
            cw.ns       = S_HALT;
            dec_illegal = 1'b1;
          end
        endcase
        if (arith) begin
          cw.sa = rn;
          cw.da = rd;
          cw.rw = 1'b1;
          if (imm) cw.b_sel = 1'b1;
          else     cw.sb    = rm;
        end
      end
      S_LOAD1: begin
        cw.sa    = rn;
        cw.b_sel = 1'b1;
        cw.cgs   = 3'b001;
        cw.fs    = FS_ADD;
        cw.ds    = 2'b11;
        cw.da    = rd;
        cw.rw    = 1'b1;
        cw.size  = 2'b11;
        cw.ns    = S_FETCH0;
      end
      default: cw.ns = S_HALT;
    endcase
    if (cw.da == ZERO_REG) cw.rw = 1'b0;
  end

  assign bus.ControlWord = cw;
  assign halted          = state[2];

endmodule
